overlay_frame_ctrl: RTL
=======================

// Module: overlay_frame_ctrl
// PURPOSE
// Frame-synchronous controller for the object/Kalman marker overlay stage. It generates the
// VGA pixel coordinates, accepts centre updates from the tracker and Kalman filter over
// valid/ready handshakes, and double-buffers them. Updates are committed only at start of
// frame, so markers never tear mid-frame. Drives x/y_pos, x/y_obj, x/y_kalman, enable and
// enable_kalman of the overlay stage and runs the track/coast/lost state machine.
// PARAMETERS
// DISP_WIDTH   11   width of all coordinates
// H_ACTIVE     640  active pixels per line; incoming x clamped to H_ACTIVE-1
// V_ACTIVE     480  active lines per frame; incoming y clamped to V_ACTIVE-1
// LOST_FRAMES  8    consecutive frames without an object update before marker is dropped
// MISS_W       4    width of miss counter; must hold LOST_FRAMES
// PORTS
// clk            in   1           pixel clock
// aresetn        in   1           asynchronous, active-low reset
// pix_valid      in   1           active pixel present this cycle
// sof            in   1           first pixel of frame; qualified by pix_valid
// eol            in   1           last pixel of line; qualified by pix_valid
// kal_en_cfg     in   1           software enable for Kalman marker
// obj_valid      in   1           tracker centre update valid
// obj_x, obj_y   in   DISP_WIDTH  tracker centre
// obj_ready      out  1           update accepted when obj_valid & obj_ready
// kal_valid      in   1           Kalman centre update valid
// kal_x, kal_y   in   DISP_WIDTH  Kalman predicted centre
// kal_ready      out  1           update accepted when kal_valid & kal_ready
// x_pos, y_pos   out  DISP_WIDTH  coordinate of pixel accepted on previous pix_valid cycle
// x_obj, y_obj   out  DISP_WIDTH  committed object centre
// x_kalman, y_kalman out DISP_WIDTH committed Kalman centre
// enable         out  1           object marker enable
// enable_kalman  out  1           Kalman marker enable
// track_state    out  2           FSM state: 0 IDLE, 1 TRACK, 2 COAST
// BEHAVIOUR
// - Reset: all outputs 0, except obj_ready/kal_ready, which are 1. State IDLE. Shadows empty,
//   miss_cnt 0, sof_seen 0. Reset mid-frame discards shadows; counting restarts at next sof.
// - Coordinates are registered with 1-cycle latency. On pix_valid&sof: x=0, y=0, sof_seen=1.
//   On pix_valid&eol: next x=0, y+1. Other pix_valid cycles: x+1. All counters hold when
//   !pix_valid. x wraps to 0 at H_ACTIVE-1 without eol. y wraps to 0 at V_ACTIVE-1.
//   Before the first sof, counters hold 0.
// - Handshake: ready is 1 except in the commit cycle (pix_valid&sof), when it is 0. A
//   transfer loads the clamped value into the shadow and sets pending. A later transfer
//   before commit overwrites the shadow (last wins).
// - Commit, on pix_valid&sof only:
//   - If obj pending: x/y_obj <= shadow, pending clear, miss_cnt <= 0.
//   - Else: miss_cnt <= miss_cnt+1, saturating at LOST_FRAMES.
//   - If kal pending: x/y_kalman <= shadow, kal_seen <= 1.
// - FSM, evaluated only at commit:
//   - IDLE -> TRACK when obj pending.
//   - TRACK -> COAST when no obj pending.
//   - COAST -> TRACK when obj pending.
//   - COAST -> IDLE when miss_cnt+1 == LOST_FRAMES. Kalman shadow and kal_seen clear.
// - enable = (state != IDLE). enable_kalman = enable & kal_seen & kal_en_cfg. kal_en_cfg is
//   sampled at commit only. Both outputs are registered and change only at commit.
// - Unqualified sof or eol (pix_valid=0) is ignored. sof&eol in the same cycle: treated as
//   sof, next x=0, y=1.
// STRUCTURE
// - overlay_pkg: state enum (IDLE/TRACK/COAST), DISP_WIDTH default, clamp function.
// - Sub-module pos_shadow_reg: handshake, clamp, shadow, pending. Instantiated twice
//   (obj, kal). Top holds pixel counters, miss counter and FSM.
// TESTING
// - Reset mid-frame at x=100: all outputs 0, ready=1. After the next sof, x_pos=0, y_pos=0.
// - 640x480 raster with eol: x_pos runs 0..639 then 0, y_pos increments. After line 479,
//   the next sof gives y_pos=0.
// - obj(200,150) sent mid-frame: x_obj stays 0 until sof. Cycle after sof: x_obj=200,
//   y_obj=150, enable=1, state TRACK.
// - Two obj updates in one frame, (10,10) then (20,30): the commit applies (20,30).
//   obj_valid held in the sof cycle: obj_ready=0, accepted next cycle.
// - Stop updates after TRACK: COAST after frame 1, IDLE and enable=0 after 8 frames.
//   One update at frame 5 returns to TRACK, miss_cnt=0.
// - kal(900,700) with kal_en_cfg=1: committed as (639,479), enable_kalman=1. kal_en_cfg=0 at
//   the next sof: enable_kalman=0.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types and helpers for the overlay frame controller: tracking FSM encoding
// and the coordinate clamp used on incoming centre updates.
`default_nettype none

package overlay_pkg;

  localparam int DISP_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_COAST = 2'd2
  } track_state_e;

  // Operands are widened to 16 bits so any coordinate width up to 16 can share it.
  function automatic logic [15:0] clamp_coord(input logic [15:0] v, input logic [15:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pos_shadow_reg.sv
// One centre-update channel: valid/ready handshake, clamp to the active area,
// shadow storage and pending flag consumed at the frame commit.
`default_nettype none

module pos_shadow_reg
  import overlay_pkg::*;
#(
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  valid_i,
  input  logic [DISP_WIDTH-1:0] x_i,
  input  logic [DISP_WIDTH-1:0] y_i,
  input  logic                  commit_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  pending_o,
  output logic [DISP_WIDTH-1:0] shadow_x_o,
  output logic [DISP_WIDTH-1:0] shadow_y_o
);

  logic                  pending_q;
  logic [DISP_WIDTH-1:0] shadow_x_q;
  logic [DISP_WIDTH-1:0] shadow_y_q;
  logic                  w_xfer;
  logic [DISP_WIDTH-1:0] w_x_clamped;
  logic [DISP_WIDTH-1:0] w_y_clamped;

  // Refusing transfers in the commit cycle keeps load and consume mutually exclusive.
  assign ready_o     = ~commit_i;
  assign w_xfer      = valid_i & ready_o;
  assign w_x_clamped = DISP_WIDTH'(clamp_coord(16'(x_i), 16'(X_MAX)));
  assign w_y_clamped = DISP_WIDTH'(clamp_coord(16'(y_i), 16'(Y_MAX)));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q  <= 1'b0;
      shadow_x_q <= '0;
      shadow_y_q <= '0;
    end else if (flush_i) begin
      pending_q  <= 1'b0;
      shadow_x_q <= '0;
      shadow_y_q <= '0;
    end else if (w_xfer) begin
      pending_q  <= 1'b1;
      shadow_x_q <= w_x_clamped;
      shadow_y_q <= w_y_clamped;
    end else if (commit_i) begin
      pending_q  <= 1'b0;
    end
  end

  assign pending_o  = pending_q;
  assign shadow_x_o = shadow_x_q;
  assign shadow_y_o = shadow_y_q;

endmodule

`default_nettype wire

// File: rtl/overlay_frame_ctrl.sv
// Frame-synchronous overlay controller: pixel coordinate counters, double-buffered
// object/Kalman centres committed at start of frame, and the track/coast/lost FSM.
`default_nettype none

module overlay_frame_ctrl
  import overlay_pkg::*;
#(
  parameter int DISP_WIDTH  = DISP_WIDTH_DEF,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOST_FRAMES = 8,
  parameter int MISS_W      = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  pix_valid,
  input  logic                  sof,
  input  logic                  eol,
  input  logic                  kal_en_cfg,
  input  logic                  obj_valid,
  input  logic [DISP_WIDTH-1:0] obj_x,
  input  logic [DISP_WIDTH-1:0] obj_y,
  output logic                  obj_ready,
  input  logic                  kal_valid,
  input  logic [DISP_WIDTH-1:0] kal_x,
  input  logic [DISP_WIDTH-1:0] kal_y,
  output logic                  kal_ready,
  output logic [DISP_WIDTH-1:0] x_pos,
  output logic [DISP_WIDTH-1:0] y_pos,
  output logic [DISP_WIDTH-1:0] x_obj,
  output logic [DISP_WIDTH-1:0] y_obj,
  output logic [DISP_WIDTH-1:0] x_kalman,
  output logic [DISP_WIDTH-1:0] y_kalman,
  output logic                  enable,
  output logic                  enable_kalman,
  output logic [1:0]            track_state
);

  localparam logic [DISP_WIDTH-1:0] X_LAST   = DISP_WIDTH'(H_ACTIVE - 1);
  localparam logic [DISP_WIDTH-1:0] Y_LAST   = DISP_WIDTH'(V_ACTIVE - 1);
  localparam logic [MISS_W-1:0]     MISS_SAT = MISS_W'(LOST_FRAMES);
  localparam logic [MISS_W-1:0]     MISS_END = MISS_W'(LOST_FRAMES - 1);

  logic                  commit;
  logic                  obj_pend, kal_pend, lost;
  logic [DISP_WIDTH-1:0] obj_sx, obj_sy, kal_sx, kal_sy;

  logic [DISP_WIDTH-1:0] x_q, y_q, nx_q, ny_q;
  logic                  sof_seen_q;

  track_state_e          state_q, state_d;
  logic [MISS_W-1:0]     miss_q;
  logic                  kal_seen_q, kal_seen_d;
  logic                  enable_q, enable_kal_q, enable_d;
  logic [DISP_WIDTH-1:0] x_obj_q, y_obj_q, x_kal_q, y_kal_q;

  assign commit = pix_valid & sof;

  pos_shadow_reg #(.DISP_WIDTH(DISP_WIDTH), .X_MAX(H_ACTIVE - 1), .Y_MAX(V_ACTIVE - 1)) u_obj (
    .clk(clk), .aresetn(aresetn), .valid_i(obj_valid), .x_i(obj_x), .y_i(obj_y),
    .commit_i(commit), .flush_i(1'b0), .ready_o(obj_ready), .pending_o(obj_pend),
    .shadow_x_o(obj_sx), .shadow_y_o(obj_sy)
  );

  pos_shadow_reg #(.DISP_WIDTH(DISP_WIDTH), .X_MAX(H_ACTIVE - 1), .Y_MAX(V_ACTIVE - 1)) u_kal (
    .clk(clk), .aresetn(aresetn), .valid_i(kal_valid), .x_i(kal_x), .y_i(kal_y),
    .commit_i(commit), .flush_i(lost), .ready_o(kal_ready), .pending_o(kal_pend),
    .shadow_x_o(kal_sx), .shadow_y_o(kal_sy)
  );

  // nx/ny hold the coordinate the next accepted pixel will take, so eol can be
  // applied after its own pixel has been reported.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_q        <= '0;
      y_q        <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      sof_seen_q <= 1'b0;
    end else if (commit) begin
      x_q        <= '0;
      y_q        <= '0;
      sof_seen_q <= 1'b1;
      nx_q       <= eol ? '0 : ((X_LAST == '0) ? '0 : DISP_WIDTH'(1));
      ny_q       <= eol ? ((Y_LAST == '0) ? '0 : DISP_WIDTH'(1)) : '0;
    end else if (pix_valid && sof_seen_q) begin
      x_q <= nx_q;
      y_q <= ny_q;
      if (eol) begin
        nx_q <= '0;
        ny_q <= (ny_q == Y_LAST) ? '0 : ny_q + 1'b1;
      end else begin
        nx_q <= (nx_q == X_LAST) ? '0 : nx_q + 1'b1;
      end
    end
  end

  assign lost = (state_q == ST_COAST) && !obj_pend && (miss_q == MISS_END);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (obj_pend) state_d = ST_TRACK;
      ST_TRACK: if (!obj_pend) state_d = ST_COAST;
      ST_COAST: begin
        if (obj_pend)  state_d = ST_TRACK;
        else if (lost) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign kal_seen_d = lost ? 1'b0 : (kal_pend ? 1'b1 : kal_seen_q);
  assign enable_d   = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      miss_q       <= '0;
      kal_seen_q   <= 1'b0;
      enable_q     <= 1'b0;
      enable_kal_q <= 1'b0;
      x_obj_q      <= '0;
      y_obj_q      <= '0;
      x_kal_q      <= '0;
      y_kal_q      <= '0;
    end else if (commit) begin
      state_q      <= state_d;
      kal_seen_q   <= kal_seen_d;
      enable_q     <= enable_d;
      enable_kal_q <= enable_d & kal_seen_d & kal_en_cfg;
      if (obj_pend) begin
        x_obj_q <= obj_sx;
        y_obj_q <= obj_sy;
        miss_q  <= '0;
      end else if (miss_q != MISS_SAT) begin
        miss_q  <= miss_q + 1'b1;
      end
      if (kal_pend && !lost) begin
        x_kal_q <= kal_sx;
        y_kal_q <= kal_sy;
      end
    end
  end

  assign x_pos         = x_q;
  assign y_pos         = y_q;
  assign x_obj         = x_obj_q;
  assign y_obj         = y_obj_q;
  assign x_kalman      = x_kal_q;
  assign y_kalman      = y_kal_q;
  assign enable        = enable_q;
  assign enable_kalman = enable_kal_q;
  assign track_state   = state_q;

endmodule

`default_nettype wire
